// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline types: stage-buffer state encoding and the payload groupings
// that get packed into a stage's DATA_W-bit payload.
package pipe_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_e;

  typedef struct packed {
    logic       en;
    logic [2:0] size;
    logic       sign_ext;
  } LoadType;

  typedef struct packed {
    logic       en;
    logic [2:0] size;
  } StoreType;

  typedef struct packed {
    logic       en;
    logic [4:0] addr;
  } RegsWrType;

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } ExceptinPipeType;

  function automatic logic [1:0] occupancy_of(pipe_state_e s);
    case (s)
      PS_BUSY: return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side (in_*)
// and downstream side (out_*). The stage itself uses the slave modport.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 160
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter; clr wins over inc, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 160,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [1:0]       occupancy,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready;
  logic              out_valid;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != PS_EMPTY);

  // With the skid entry, in_ready depends only on state, never on out_ready.
  if (SKID != 0) begin : g_skid
    assign in_ready = rst | (state_q != PS_FULL);
  end else begin : g_noskid
    assign in_ready = rst | ~out_valid | bus.out_ready;
  end

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_BUSY;
            main_d  = bus.in_data;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            state_d = PS_FULL;
            skid_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_d = PS_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~bus.out_ready),
    .clr   (clr_stats),
    .count (stall_cnt)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign occupancy     = occupancy_of(state_q);
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives three stage configurations (skid, no-skid, skid+clear-on-flush with a
// 4-bit counter) from shared stimulus and scoreboards each against a FIFO model.
module tb_pipe_stage_buf;
  localparam int DW = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, clr_stats, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic [N-1:0]         ir, ov;
  logic [N-1:0][DW-1:0] od;
  logic [N-1:0][1:0]    occ;
  logic [N-1:0][15:0]   sc;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int SK = (gi == 1) ? 0 : 1;
    localparam int CL = (gi == 2) ? 1 : 0;
    localparam int CW = (gi == 2) ? 4 : 16;

    pipe_stage_buf_if #(.DATA_W(DW)) bus ();
    logic [CW-1:0] cnt;

    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;

    pipe_stage_buf #(
      .DATA_W(DW), .SKID(SK), .CLEAR_ON_FLUSH(CL), .CNT_W(CW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .occupancy (occ[gi]),
      .clr_stats (clr_stats),
      .stall_cnt (cnt)
    );

    assign ir[gi]  = bus.in_ready;
    assign ov[gi]  = bus.out_valid;
    assign od[gi]  = bus.out_data;
    assign sc[gi]  = 16'(cnt);
  end

  // Reference model: per-configuration FIFO contents and stall count.
  logic [DW-1:0] mq [N][2];
  int            msz [N];
  int            mstall [N];
  bit            zero_known [N];
  bit            exp_ir [N];
  bit            exp_stalled [N];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit has_skid(int i);
    return i != 1;
  endfunction

  function automatic bit clears_on_flush(int i);
    return i == 2;
  endfunction

  function automatic int stall_max(int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  task automatic chk(input string name, input int i, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Called at the rising edge with the inputs the DUTs are sampling.
  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        msz[i]        = 0;
        mstall[i]     = 0;
        zero_known[i] = 1'b1;
      end else begin
        if (flush) begin
          msz[i] = 0;
          if (clears_on_flush(i)) zero_known[i] = 1'b1;
        end else if (in_valid && exp_ir[i] && msz[i] < 2) begin
          mq[i][msz[i]] = in_data;
          msz[i]++;
          zero_known[i] = 1'b0;
        end
        if (clr_stats) mstall[i] = 0;
        else if (exp_stalled[i] && mstall[i] < stall_max(i)) mstall[i]++;
      end
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit c, input bit v,
                       input bit o, input logic [DW-1:0] d);
    rst       = r;
    flush     = f;
    clr_stats = c;
    in_valid  = v;
    out_ready = o;
    in_data   = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Monitor: compares outputs mid-cycle and pops the head on each out_fire.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        exp_ir[i] = rst ? 1'b1 :
                    (has_skid(i) ? (msz[i] < 2) : (msz[i] == 0 || out_ready));
        chk("in_ready", i, DW'(ir[i]), DW'(exp_ir[i]));
        chk("out_valid", i, DW'(ov[i]), DW'(msz[i] > 0));
        chk("occupancy", i, DW'(occ[i]), DW'(msz[i]));
        chk("stall_cnt", i, DW'(sc[i]), DW'(mstall[i]));
        if (msz[i] > 0) chk("out_data", i, od[i], mq[i][0]);
        else if (zero_known[i]) chk("out_data_zero", i, od[i], '0);
        exp_stalled[i] = (msz[i] > 0) && !out_ready;
        if (!rst && msz[i] > 0 && out_ready) begin
          $display("beat dut%0d data=%0h", i, mq[i][0]);
          mq[i][0] = mq[i][1];
          msz[i]--;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      msz[i] = 0; mstall[i] = 0; zero_known[i] = 1'b1;
      exp_ir[i] = 1'b1; exp_stalled[i] = 1'b0;
    end
    // reset, then idle
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    repeat (2) drive(0, 0, 0, 0, 0, '0);
    // streaming pass-through
    for (int k = 1; k <= 3; k++) drive(0, 0, 0, 1, 1, DW'(k));
    repeat (2) drive(0, 0, 0, 0, 1, '0);
    // backpressure fills the skid entry, then drains in order
    drive(0, 0, 0, 1, 0, 32'h0000_00A0);
    drive(0, 0, 0, 1, 0, 32'h0000_00B0);
    repeat (2) drive(0, 0, 0, 0, 0, '0);
    repeat (3) drive(0, 0, 0, 0, 1, '0);
    // flush while full with a beat offered
    drive(0, 0, 0, 1, 0, 32'h0000_00C0);
    drive(0, 0, 0, 1, 0, 32'h0000_00D0);
    drive(0, 1, 0, 1, 0, 32'h0000_00E0);
    repeat (2) drive(0, 0, 0, 0, 1, '0);
    // stalled head, then release with a beat offered
    drive(0, 0, 0, 1, 0, 32'h0000_00F0);
    drive(0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 1, 1, 32'h0000_0100);
    drive(0, 0, 0, 1, 1, 32'h0000_0101);
    repeat (2) drive(0, 0, 0, 0, 1, '0);
    // long stall saturates the narrow counter; clear mid-stall; reset mid-stream
    drive(0, 0, 0, 1, 0, 32'h0000_0200);
    repeat (20) drive(0, 0, 0, 0, 0, '0);
    drive(0, 0, 1, 0, 0, '0);
    repeat (3) drive(0, 0, 0, 1, 0, 32'h0000_0201);
    drive(1, 0, 0, 1, 0, 32'h0000_0202);
    repeat (2) drive(0, 0, 0, 0, 1, '0);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 32) == 0),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6), DW'($urandom));
    end
    repeat (4) drive(0, 0, 0, 0, 1, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
